// File: rtl/axi4_mem_scheduler.sv
// axi4_mem_scheduler: shares one valid/ack memory port between the fetch read,
// EX read and EX write requesters. It keeps one transaction outstanding, arbitrates
// round-robin and holds each grant for a whole transaction.
// Optional feature macro SCHED_TIMEOUT_EN: aborts WAIT after TIMEOUT cycles with err.
`timescale 1ns/1ps

module axi4_mem_scheduler #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                instr_req,
    input  logic [ADDR_W-1:0]   instr_addr,
    output logic                instr_done,
    output logic [DATA_W-1:0]   instr_rdata,
    input  logic                ex_rd_req,
    output logic                ex_rd_done,
    output logic [DATA_W-1:0]   ex_rdata,
    input  logic                ex_wr_req,
    output logic                ex_wr_done,
    input  logic [ADDR_W-1:0]   ex_addr,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic [DATA_W/8-1:0] ex_wstrb,
    output logic                err,
    output logic                mem_rd_valid,
    output logic                mem_wr_valid,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] G_INSTR = 2'd0;
    localparam logic [1:0] G_RD    = 2'd1;
    localparam logic [1:0] G_WR    = 2'd2;

    logic [1:0] state;
    logic [1:0] grant;
    logic [1:0] rr_ptr;
    logic [1:0] next_grant;
    logic       any_req;

`ifdef SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;
    logic             expire;

    // The counter reaches TIMEOUT on the TIMEOUT-th WAIT cycle without an ack
    always_comb begin
        expire = ((wait_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT));
    end

    // Wait counter and abort flag, both cleared when a new transaction is issued
    always_ff @(posedge CLK) begin
        if (RST) begin
            wait_cnt  <= '0;
            timed_out <= 1'b0;
        end else if (state == S_ISSUE) begin
            wait_cnt  <= '0;
            timed_out <= 1'b0;
        end else if (state == S_WAIT) begin
            wait_cnt  <= wait_cnt + CNT_W'(1);
            timed_out <= !mem_ack && expire;
        end
    end

    assign err = (state == S_RESP) && timed_out;
`else
    logic expire;
    assign expire = 1'b0;
    assign err    = 1'b0;
`endif

    // Round-robin pick starting at rr_ptr in the order instr -> ex_rd -> ex_wr
    always_comb begin
        any_req    = instr_req | ex_rd_req | ex_wr_req;
        next_grant = rr_ptr;
        case (rr_ptr)
            G_INSTR: next_grant = instr_req ? G_INSTR : (ex_rd_req ? G_RD : G_WR);
            G_RD:    next_grant = ex_rd_req ? G_RD    : (ex_wr_req ? G_WR : G_INSTR);
            default: next_grant = ex_wr_req ? G_WR    : (instr_req ? G_INSTR : G_RD);
        endcase
    end

    // Transaction FSM: latches the grant and its payload, waits for ack, then completes
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_IDLE;
            grant       <= G_INSTR;
            rr_ptr      <= G_INSTR;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
            instr_rdata <= '0;
            ex_rdata    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        grant    <= next_grant;
                        mem_addr <= (next_grant == G_INSTR) ? instr_addr : ex_addr;
                        if (next_grant == G_WR) begin
                            mem_wdata <= ex_wdata;
                            mem_wstrb <= ex_wstrb;
                        end
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (mem_ack) begin
                        if (grant == G_INSTR) instr_rdata <= mem_rdata;
                        if (grant == G_RD)    ex_rdata    <= mem_rdata;
                        state <= S_RESP;
                    end else if (expire) begin
                        state <= S_RESP;
                    end
                end
                default: begin
                    rr_ptr <= (grant == G_WR) ? G_INSTR : grant + 2'd1;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    // Issue pulses and done pulses are decoded from the state and the held grant
    always_comb begin
        mem_rd_valid = (state == S_ISSUE) && (grant != G_WR);
        mem_wr_valid = (state == S_ISSUE) && (grant == G_WR);
        instr_done   = (state == S_RESP)  && (grant == G_INSTR);
        ex_rd_done   = (state == S_RESP)  && (grant == G_RD);
        ex_wr_done   = (state == S_RESP)  && (grant == G_WR);
    end

endmodule

// File: tb/tb_axi4_mem_scheduler.sv
// tb_axi4_mem_scheduler: directed self-checking bench for axi4_mem_scheduler.
// Optional feature macro SCHED_TIMEOUT_EN adds the timeout scenarios.
`timescale 1ns/1ps

module tb_axi4_mem_scheduler;

    logic        CLK = 1'b0;
    logic        RST;
    logic        instr_req;
    logic [63:0] instr_addr;
    logic        instr_done;
    logic [63:0] instr_rdata;
    logic        ex_rd_req;
    logic        ex_rd_done;
    logic [63:0] ex_rdata;
    logic        ex_wr_req;
    logic        ex_wr_done;
    logic [63:0] ex_addr;
    logic [63:0] ex_wdata;
    logic [7:0]  ex_wstrb;
    logic        err;
    logic        mem_rd_valid;
    logic        mem_wr_valid;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    int pass_cnt  = 0;
    int check_cnt = 0;

    axi4_mem_scheduler #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_done(instr_done),
        .instr_rdata(instr_rdata),
        .ex_rd_req(ex_rd_req), .ex_rd_done(ex_rd_done), .ex_rdata(ex_rdata),
        .ex_wr_req(ex_wr_req), .ex_wr_done(ex_wr_done), .ex_addr(ex_addr),
        .ex_wdata(ex_wdata), .ex_wstrb(ex_wstrb), .err(err),
        .mem_rd_valid(mem_rd_valid), .mem_wr_valid(mem_wr_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    // Free-running 10 ns clock
    always #5 CLK = ~CLK;

    // Advance one rising edge and settle before sampling
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; instr_req = 0; ex_rd_req = 0; ex_wr_req = 0;
        instr_addr = '0; ex_addr = '0; ex_wdata = '0; ex_wstrb = '0;
        mem_ack = 0; mem_rdata = '0;
        step(); step();
        RST = 1'b0;
        step();
        check_cnt++;
        if ({mem_rd_valid, mem_wr_valid, instr_done, ex_rd_done, ex_wr_done, err} !== 6'b0)
            $display("[TB] FAIL reset_pulses: got %b expected 000000",
                     {mem_rd_valid, mem_wr_valid, instr_done, ex_rd_done, ex_wr_done, err});
        else pass_cnt++;
        check_cnt++;
        if ({mem_addr, mem_wdata, mem_wstrb} !== 136'b0)
            $display("[TB] FAIL reset_mem_regs: got %h %h %h expected zeros", mem_addr, mem_wdata, mem_wstrb);
        else pass_cnt++;
        check_cnt++;
        if ({instr_rdata, ex_rdata} !== 128'b0)
            $display("[TB] FAIL reset_rdata: got %h %h expected zeros", instr_rdata, ex_rdata);
        else pass_cnt++;
    endtask

    task automatic test_fetch();
        instr_req = 1; instr_addr = 64'h8000_0000;
        step();   // cycle 1: ISSUE
        check_cnt++;
        if (mem_rd_valid !== 1'b1 || mem_wr_valid !== 1'b0)
            $display("[TB] FAIL fetch_valid: got rd=%b wr=%b expected rd=1 wr=0", mem_rd_valid, mem_wr_valid);
        else pass_cnt++;
        check_cnt++;
        if (mem_addr !== 64'h8000_0000)
            $display("[TB] FAIL fetch_addr: got %h expected 80000000", mem_addr);
        else pass_cnt++;
        step();   // cycle 2: WAIT
        check_cnt++;
        if (mem_rd_valid !== 1'b0 || instr_done !== 1'b0)
            $display("[TB] FAIL fetch_valid_pulse: got valid=%b done=%b expected 0 0", mem_rd_valid, instr_done);
        else pass_cnt++;
        mem_ack = 1; mem_rdata = 64'h13;
        step();   // cycle 3: RESP
        mem_ack = 0; mem_rdata = 64'hFFFF;
        check_cnt++;
        if ({instr_done, ex_rd_done, ex_wr_done} !== 3'b100)
            $display("[TB] FAIL fetch_done: got %b expected 100", {instr_done, ex_rd_done, ex_wr_done});
        else pass_cnt++;
        check_cnt++;
        if (instr_rdata !== 64'h13)
            $display("[TB] FAIL fetch_rdata: got %h expected 13", instr_rdata);
        else pass_cnt++;
        instr_req = 0;
        step();   // cycle 4: IDLE
        check_cnt++;
        if (instr_done !== 1'b0 || mem_rd_valid !== 1'b0)
            $display("[TB] FAIL fetch_done_pulse: got done=%b valid=%b expected 0 0", instr_done, mem_rd_valid);
        else pass_cnt++;
    endtask

    task automatic test_write();
        ex_wr_req = 1; ex_addr = 64'h8000_1000; ex_wdata = 64'hDEAD_BEEF; ex_wstrb = 8'h0F;
        step();
        check_cnt++;
        if (mem_wr_valid !== 1'b1 || mem_rd_valid !== 1'b0)
            $display("[TB] FAIL write_valid: got wr=%b rd=%b expected wr=1 rd=0", mem_wr_valid, mem_rd_valid);
        else pass_cnt++;
        check_cnt++;
        if (mem_addr !== 64'h8000_1000 || mem_wdata !== 64'hDEAD_BEEF || mem_wstrb !== 8'h0F)
            $display("[TB] FAIL write_payload: got %h %h %h expected 80001000 deadbeef 0f",
                     mem_addr, mem_wdata, mem_wstrb);
        else pass_cnt++;
        ex_wdata = 64'h1111; ex_wstrb = 8'hF0;
        step();
        check_cnt++;
        if (mem_wr_valid !== 1'b0)
            $display("[TB] FAIL write_valid_pulse: got %b expected 0", mem_wr_valid);
        else pass_cnt++;
        mem_ack = 1; mem_rdata = 64'hBAD0_BAD0;
        step();
        mem_ack = 0;
        check_cnt++;
        if ({instr_done, ex_rd_done, ex_wr_done} !== 3'b001)
            $display("[TB] FAIL write_done: got %b expected 001", {instr_done, ex_rd_done, ex_wr_done});
        else pass_cnt++;
        check_cnt++;
        if (ex_rdata !== 64'h0 || instr_rdata !== 64'h13)
            $display("[TB] FAIL write_rdata_hold: got %h %h expected 0 13", ex_rdata, instr_rdata);
        else pass_cnt++;
        check_cnt++;
        if (mem_wdata !== 64'hDEAD_BEEF || mem_wstrb !== 8'h0F)
            $display("[TB] FAIL write_hold: got %h %h expected deadbeef 0f", mem_wdata, mem_wstrb);
        else pass_cnt++;
        ex_wr_req = 0;
        step();
    endtask

    // One transaction with a bounded wait for the issue pulse and an ack one cycle later
    task automatic do_txn(input logic [1:0] exp_id, input logic [63:0] exp_addr,
                          input logic [63:0] rd_val, input string tag);
        int   n;
        logic seen;
        logic exp_wr;
        n = 0; seen = 0; exp_wr = (exp_id == 2'd2);
        while (n < 10 && !seen) begin
            step();
            n++;
            if (mem_rd_valid || mem_wr_valid) seen = 1;
        end
        check_cnt++;
        if (!seen || mem_wr_valid !== exp_wr || mem_rd_valid !== !exp_wr)
            $display("[TB] FAIL %s_kind: got seen=%b rd=%b wr=%b expected wr=%b",
                     tag, seen, mem_rd_valid, mem_wr_valid, exp_wr);
        else pass_cnt++;
        check_cnt++;
        if (mem_addr !== exp_addr)
            $display("[TB] FAIL %s_addr: got %h expected %h", tag, mem_addr, exp_addr);
        else pass_cnt++;
        step();
        mem_ack = 1; mem_rdata = rd_val;
        step();
        mem_ack = 0;
        check_cnt++;
        if ({ex_wr_done, ex_rd_done, instr_done} !== (3'b001 << exp_id) || err !== 1'b0)
            $display("[TB] FAIL %s_done: got %b err=%b expected %b err=0",
                     tag, {ex_wr_done, ex_rd_done, instr_done}, err, 3'b001 << exp_id);
        else pass_cnt++;
        if (exp_id == 2'd0) begin
            check_cnt++;
            if (instr_rdata !== rd_val)
                $display("[TB] FAIL %s_rdata: got %h expected %h", tag, instr_rdata, rd_val);
            else pass_cnt++;
        end else if (exp_id == 2'd1) begin
            check_cnt++;
            if (ex_rdata !== rd_val)
                $display("[TB] FAIL %s_rdata: got %h expected %h", tag, ex_rdata, rd_val);
            else pass_cnt++;
        end
    endtask

    task automatic test_round_robin();
        instr_addr = 64'hA000; ex_addr = 64'hB000; ex_wdata = 64'h77; ex_wstrb = 8'hFF;
        instr_req = 1; ex_rd_req = 1; ex_wr_req = 1;
        do_txn(2'd0, 64'hA000, 64'h0A0A, "rr_instr1");
        do_txn(2'd1, 64'hB000, 64'h0B0B, "rr_exrd");
        do_txn(2'd2, 64'hB000, 64'h0C0C, "rr_exwr");
        do_txn(2'd0, 64'hA000, 64'h0D0D, "rr_instr2");
        instr_req = 0; ex_rd_req = 0; ex_wr_req = 0;
        step();
        check_cnt++;
        if (ex_rdata !== 64'h0B0B)
            $display("[TB] FAIL rr_exrdata_hold: got %h expected 0b0b", ex_rdata);
        else pass_cnt++;
    endtask

    task automatic test_midflight();
        ex_rd_req = 1; ex_addr = 64'h100;
        step();   // ISSUE
        check_cnt++;
        if (mem_rd_valid !== 1'b1 || mem_addr !== 64'h100)
            $display("[TB] FAIL mid_issue: got valid=%b addr=%h expected 1 100", mem_rd_valid, mem_addr);
        else pass_cnt++;
        ex_addr = 64'h200; mem_ack = 1; mem_rdata = 64'hEEEE;
        step();   // WAIT, ack during ISSUE was ignored
        mem_ack = 0;
        step();
        check_cnt++;
        if (ex_rd_done !== 1'b0 || mem_addr !== 64'h100)
            $display("[TB] FAIL mid_wait: got done=%b addr=%h expected 0 100", ex_rd_done, mem_addr);
        else pass_cnt++;
        mem_ack = 1; mem_rdata = 64'h5555;
        step();   // RESP
        mem_ack = 0;
        check_cnt++;
        if (ex_rd_done !== 1'b1 || ex_rdata !== 64'h5555 || mem_addr !== 64'h100)
            $display("[TB] FAIL mid_resp: got done=%b rdata=%h addr=%h expected 1 5555 100",
                     ex_rd_done, ex_rdata, mem_addr);
        else pass_cnt++;
        ex_rd_req = 0;
        step();
    endtask

    task automatic test_reset_midflight();
        // Pointer now selects ex_wr, so it is granted first here
        ex_wr_req = 1; ex_addr = 64'h300; ex_wdata = 64'h4242; ex_wstrb = 8'hFF;
        step(); step();   // ISSUE, WAIT
        check_cnt++;
        if (mem_addr !== 64'h300 || mem_wstrb !== 8'hFF)
            $display("[TB] FAIL rst_pre: got addr=%h strb=%h expected 300 ff", mem_addr, mem_wstrb);
        else pass_cnt++;
        RST = 1;
        step();
        RST = 0; ex_wr_req = 0;
        check_cnt++;
        if ({mem_rd_valid, mem_wr_valid, instr_done, ex_rd_done, ex_wr_done, err} !== 6'b0 ||
            {mem_addr, mem_wdata, mem_wstrb, instr_rdata, ex_rdata} !== 264'b0)
            $display("[TB] FAIL rst_mid_outputs: got addr=%h wdata=%h strb=%h irdata=%h exrdata=%h expected zeros",
                     mem_addr, mem_wdata, mem_wstrb, instr_rdata, ex_rdata);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            step();
            check_cnt++;
            if ({instr_done, ex_rd_done, ex_wr_done, mem_rd_valid, mem_wr_valid} !== 5'b0)
                $display("[TB] FAIL rst_no_done: got %b expected 00000",
                         {instr_done, ex_rd_done, ex_wr_done, mem_rd_valid, mem_wr_valid});
            else pass_cnt++;
        end
        instr_addr = 64'hC000; ex_addr = 64'hD000;
        instr_req = 1; ex_rd_req = 1; ex_wr_req = 1;
        do_txn(2'd0, 64'hC000, 64'h9999, "rst_first_grant");
        instr_req = 0; ex_rd_req = 0; ex_wr_req = 0;
        step();
    endtask

`ifdef SCHED_TIMEOUT_EN
    task automatic test_timeout();
        instr_req = 1; instr_addr = 64'hE000;
        step(); step();   // ISSUE, first WAIT cycle
        for (int i = 0; i < 3; i++) begin
            step();
            check_cnt++;
            if (instr_done !== 1'b0 || err !== 1'b0)
                $display("[TB] FAIL tmo_early: got done=%b err=%b expected 0 0", instr_done, err);
            else pass_cnt++;
        end
        step();   // RESP after the fourth WAIT cycle
        check_cnt++;
        if (instr_done !== 1'b1 || err !== 1'b1 || instr_rdata !== 64'h9999)
            $display("[TB] FAIL tmo_abort: got done=%b err=%b rdata=%h expected 1 1 9999",
                     instr_done, err, instr_rdata);
        else pass_cnt++;
        instr_req = 0;
        step();
        instr_req = 1;
        step(); step(); step(); step(); step();   // ISSUE, WAIT 1..4
        mem_ack = 1; mem_rdata = 64'h7777;
        step();
        mem_ack = 0;
        check_cnt++;
        if (instr_done !== 1'b1 || err !== 1'b0 || instr_rdata !== 64'h7777)
            $display("[TB] FAIL tmo_ack_wins: got done=%b err=%b rdata=%h expected 1 0 7777",
                     instr_done, err, instr_rdata);
        else pass_cnt++;
        instr_req = 0;
        step();
    endtask
`endif

    // Scenario sequence and summary
    initial begin
        test_reset();
        test_fetch();
        test_write();
        test_round_robin();
        test_midflight();
        test_reset_midflight();
`ifdef SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
